// File: rtl/out_port_buf_if.sv
// Store-side and display-side signal bundle for out_port_buf.
// ovf_count exists only when OUT_PORT_OVF_CNT_EN is defined.
interface out_port_buf_if #(
    parameter int DEPTH = 4
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic          we;
    logic          wr_ready;
    logic [31:0]   data_out;
    logic          out_valid;
    logic [LW-1:0] level;
    logic          empty;
    logic          full;
    logic          fsm_state;   // 0 = IDLE, 1 = SHOW
`ifdef OUT_PORT_OVF_CNT_EN
    logic [15:0]   ovf_count;
`endif

    // Handshake: a store is taken on a rising edge where we=1, addr matches the
    // port address and wr_ready=1; a store presented while wr_ready=0 is lost.
    modport master (
        output addr, wdata, we,
        input  wr_ready, data_out, out_valid, level, empty, full, fsm_state
`ifdef OUT_PORT_OVF_CNT_EN
        , input ovf_count
`endif
    );

    modport slave (
        input  addr, wdata, we,
        output wr_ready, data_out, out_valid, level, empty, full, fsm_state
`ifdef OUT_PORT_OVF_CNT_EN
        , output ovf_count
`endif
    );
endinterface

// File: rtl/out_port_buf.sv
// FIFO-buffered output port that holds each stored word on data_out for HOLD_CYCLES.
// Optional rejected-store counter enabled by defining OUT_PORT_OVF_CNT_EN.
module out_port_buf #(
    parameter int          DEPTH       = 4,
    parameter int          HOLD_CYCLES = 25000000,
    parameter logic [31:0] PORT_ADDR   = 32'h000000C0
) (
    input  logic          clock,
    input  logic          reset,
    out_port_buf_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic {IDLE = 1'b0, SHOW = 1'b1} state_t;

    state_t        state, next_state;
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level_q;
    logic [CW-1:0] cnt;
    logic [31:0]   data_q;
    logic          full_w, hit, push, pop;

    assign full_w = (level_q == LW'(DEPTH));
    assign hit    = bus.we && (bus.addr == PORT_ADDR);
    // full comes from the registered level, so a same-edge pop never frees a slot.
    assign push   = hit && !full_w;

    always_comb begin
        next_state = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (level_q != '0) begin
                    pop        = 1'b1;
                    next_state = SHOW;
                end
            end
            SHOW: begin
                if (cnt == '0) begin
                    if (level_q != '0) pop = 1'b1;
                    else               next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= bus.wdata;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            cnt     <= '0;
            data_q  <= '0;
        end else begin
            state <= next_state;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
                data_q <= mem[rd_ptr];
                rd_ptr <= rd_ptr + AW'(1);
                cnt    <= CW'(HOLD_CYCLES - 1);
            end else if (state == SHOW && cnt != '0) begin
                cnt <= cnt - CW'(1);
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

`ifdef OUT_PORT_OVF_CNT_EN
    logic [15:0] ovf_q;

    always_ff @(posedge clock) begin
        if (reset)
            ovf_q <= '0;
        else if (hit && full_w && ovf_q != 16'hFFFF)
            ovf_q <= ovf_q + 16'd1;
    end

    assign bus.ovf_count = ovf_q;
`endif

    assign bus.wr_ready  = !full_w;
    assign bus.full      = full_w;
    assign bus.empty     = (level_q == '0);
    assign bus.level     = level_q;
    assign bus.data_out  = data_q;
    assign bus.out_valid = (state == SHOW);
    assign bus.fsm_state = state;
endmodule

// File: tb/tb_out_port_buf.sv
// Bench for out_port_buf: directed sequences, an address-decode vector table,
// and a display monitor that pops the expected-word queue and checks hold length.
module tb_out_port_buf;
    localparam int          DEPTH = 4;
    localparam int          HOLD  = 4;
    localparam logic [31:0] PA    = 32'hC0;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    out_port_buf_if #(.DEPTH(DEPTH)) bus ();

    out_port_buf #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD), .PORT_ADDR(PA)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        bus.addr  = a;
        bus.wdata = d;
        bus.we    = 1'b1;
        tick();
        bus.we    = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            if (bus.out_valid === 1'b0 && bus.empty === 1'b1) done = 1;
            else tick();
        end
        if (!done) check("wait_idle_timeout", 32'd0, 32'd1);
    endtask

    // Display monitor: a new word starts when out_valid rises or a full hold elapses.
    logic        mon_en = 1'b0;
    logic        prev_valid = 1'b0;
    logic        rst_next = 1'b0;
    int          hold_cnt = 0;
    logic [31:0] cur_word = '0;

    always @(posedge clock) begin
        #2;
        if (mon_en) begin
            if (rst_next) begin
                hold_cnt = 0;
            end else if (bus.out_valid === 1'b1) begin
                if (!prev_valid || hold_cnt == HOLD) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_word: got %0h expected none", bus.data_out);
                    end else begin
                        check("display_word", bus.data_out, exp_q.pop_front());
                    end
                    cur_word = bus.data_out;
                    hold_cnt = 1;
                end else begin
                    hold_cnt++;
                    check("hold_stable", bus.data_out, cur_word);
                end
            end else begin
                if (prev_valid) check("hold_length", 32'(hold_cnt), 32'(HOLD));
                hold_cnt = 0;
            end
            prev_valid = (bus.out_valid === 1'b1);
        end
        rst_next = reset;
    end

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        accept;
    } vec_t;

    vec_t tbl[7];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] prev;
        tbl[0] = '{1'b1, 32'hC4,       32'd99,        1'b0};
        tbl[1] = '{1'b1, 32'hC0,       32'hA5A5A5A5,  1'b1};
        tbl[2] = '{1'b0, 32'hC0,       32'h1234,      1'b0};
        tbl[3] = '{1'b1, 32'h0,        32'd7,         1'b0};
        tbl[4] = '{1'b1, 32'hFFFFFFC0, 32'd8,         1'b0};
        tbl[5] = '{1'b1, 32'hC0,       32'hFFFFFFFF,  1'b1};
        tbl[6] = '{1'b1, 32'h1C0,      32'd9,         1'b0};

        // Reset held two edges while a matching store is presented.
        reset     = 1'b1;
        bus.we    = 1'b1;
        bus.addr  = PA;
        bus.wdata = 32'h55;
        tick();
        tick();
        reset  = 1'b0;
        bus.we = 1'b0;
        check("rst_data_out", bus.data_out, 32'd0);
        check("rst_level", 32'(bus.level), 32'd0);
        check("rst_empty", 32'(bus.empty), 32'd1);
        check("rst_full", 32'(bus.full), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_wr_ready", 32'(bus.wr_ready), 32'd1);
        check("rst_fsm_idle", 32'(bus.fsm_state), 32'd0);
`ifdef OUT_PORT_OVF_CNT_EN
        check("rst_ovf_count", 32'(bus.ovf_count), 32'd0);
`endif
        mon_en = 1'b1;
        tick();
        check("rst_no_capture", 32'(bus.level), 32'd0);

        // Single word: no bypass, shown for HOLD cycles, then held in IDLE.
        exp_q.push_back(32'd37);
        store(PA, 32'd37);
        check("single_level_after_push", 32'(bus.level), 32'd1);
        check("single_no_bypass", 32'(bus.out_valid), 32'd0);
        tick();
        check("single_data", bus.data_out, 32'd37);
        check("single_valid", 32'(bus.out_valid), 32'd1);
        check("single_level_popped", 32'(bus.level), 32'd0);
        repeat (3) tick();
        check("single_valid_last", 32'(bus.out_valid), 32'd1);
        tick();
        check("single_idle_valid", 32'(bus.out_valid), 32'd0);
        check("single_idle_data", bus.data_out, 32'd37);
        check("single_idle_fsm", 32'(bus.fsm_state), 32'd0);

        // Three back-to-back words, no gap between them.
        exp_q.push_back(32'd12);
        exp_q.push_back(32'd34);
        exp_q.push_back(32'd56);
        store(PA, 32'd12);
        store(PA, 32'd34);
        store(PA, 32'd56);
        repeat (10) tick();
        check("burst_last_valid", 32'(bus.out_valid), 32'd1);
        check("burst_last_data", bus.data_out, 32'd56);
        tick();
        check("burst_end_valid", 32'(bus.out_valid), 32'd0);
        check("burst_end_data", bus.data_out, 32'd56);

        // Overflow: sixth store arrives while full and is dropped.
        wait_idle();
        for (int i = 1; i <= 5; i++) exp_q.push_back(32'(i));
        for (int i = 1; i <= 6; i++) begin
            store(PA, 32'(i));
            if (i == 5) begin
                check("ovf_full", 32'(bus.full), 32'd1);
                check("ovf_wr_ready", 32'(bus.wr_ready), 32'd0);
                check("ovf_level_full", 32'(bus.level), 32'd4);
            end
        end
        check("ovf_level_after_drop", 32'(bus.level), 32'd3);
        check("ovf_full_cleared", 32'(bus.full), 32'd0);
`ifdef OUT_PORT_OVF_CNT_EN
        check("ovf_count", 32'(bus.ovf_count), 32'd1);
`endif
        wait_idle();

        // Address decode and strobe vectors.
        for (int i = 0; i < 7; i++) begin
            wait_idle();
            prev      = bus.data_out;
            bus.we    = tbl[i].we;
            bus.addr  = tbl[i].addr;
            bus.wdata = tbl[i].wdata;
            if (tbl[i].accept) exp_q.push_back(tbl[i].wdata);
            tick();
            bus.we = 1'b0;
            check($sformatf("vec%0d_level", i), 32'(bus.level), 32'(tbl[i].accept));
            tick();
            if (!tbl[i].accept) begin
                check($sformatf("vec%0d_data_kept", i), bus.data_out, prev);
                check($sformatf("vec%0d_valid_low", i), 32'(bus.out_valid), 32'd0);
            end
        end

        // Reset during a hold with two words queued.
        wait_idle();
        exp_q.push_back(32'd77);
        store(PA, 32'd77);
        store(PA, 32'd88);
        store(PA, 32'd99);
        check("midrst_level_before", 32'(bus.level), 32'd2);
        check("midrst_data_before", bus.data_out, 32'd77);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_data", bus.data_out, 32'd0);
        check("midrst_level", 32'(bus.level), 32'd0);
        check("midrst_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_fsm", 32'(bus.fsm_state), 32'd0);
        check("midrst_empty", 32'(bus.empty), 32'd1);
`ifdef OUT_PORT_OVF_CNT_EN
        check("midrst_ovf_count", 32'(bus.ovf_count), 32'd0);
`endif
        repeat (20) tick();
        check("midrst_quiet_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_quiet_data", bus.data_out, 32'd0);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
